ctrl_pipe: RTL
==============

# ctrl_pipe

Parametrised control-signal pipeline that carries the decoded control bundle and ALU control from decode through the E/M/W stages of the pipelined MIPS core. It generalises the fixed three-stage control chain: stage count and bundle widths are configurable, every stage carries a valid bit, and per-stage stall and flush are supported with defined priorities. It also adds qualified misprediction squash and optional performance counters. It sits between `main_decoder`/`alu_dec` and the datapath and hazard unit.

## Interface
- `SIG_W`, 8: control bundle width; bit order {memen, jump, memtoreg, memwrite, branch, alusrc, regdst, regwrite} MSB..LSB.
- `ALUC_W`, 3: ALU control width.
- `STAGES`, 3: number of pipeline stages after decode (index 0 = E); legal range 2..6.
- `MISP_IDX`, 1: stage index whose outputs carry branch resolution (M); must be < STAGES.
- `clka` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sig_d` in SIG_W: decoded bundle from decode.
- `aluc_d` in ALUC_W: decoded ALU control.
- `valid_d` in 1: decode slot holds a real instruction.
- `stall` in STAGES: per-stage hold request from hazard unit.
- `flush` in STAGES: per-stage squash request.
- `pred_take` in 1: prediction carried with the instruction in stage MISP_IDX.
- `actual_take` in 1: resolved outcome in stage MISP_IDX.
- `sig_q` out STAGES*SIG_W: stage k bundle at bits [k*SIG_W +: SIG_W].
- `aluc_q` out STAGES*ALUC_W: stage k ALU control, same packing.
- `valid_q` out STAGES: stage valid bits.
- `stall_dec` out 1: decode must hold (stage 0 not accepting).
- `mispredict` out 1: combinational, valid_q[MISP_IDX] & (pred_take != actual_take).
- `flush_cnt` out 16 and `bubble_cnt` out 16: present only with CTRL_PIPE_PERF_EN.

## Operation
- Effective hold: hold[STAGES-1] = stall[STAGES-1]; hold[k] = stall[k] | hold[k+1]. Downstream stall propagates upstream.
- Effective kill: kill[k] = flush[k] | (mispredict & k <= MISP_IDX).
- Per stage per edge, priority high to low:
  - kill[k]: load bubble (valid 0, sig 0, aluc 0).
  - hold[k]: keep current contents.
  - k > 0 and hold[k-1]: load bubble, so the upstream-held instruction is not duplicated.
  - otherwise: load stage k-1, or decode inputs for k = 0.
- Kill overrides hold. A flushed stalled stage becomes a bubble and stays one while held.
- `stall_dec` = hold[0]. When hold[0] is set, decode inputs are ignored that cycle.
- Mispredict squashes stages 0..MISP_IDX. Stage MISP_IDX+1 receives the branch itself normally, which preserves existing E/M clear semantics.
- An invalid stage-MISP_IDX entry never asserts `mispredict`, whatever the prediction inputs.
- Bubbles are all-zero bundles, so regwrite/memwrite/memen are guaranteed 0.

## Timing
- Latency: decode to stage k outputs is k+1 edges when no hold or kill is active.
- All stage outputs are registers. `stall_dec` and `mispredict` are combinational from inputs and stage state, with no register path from the `stall` inputs.
- Reset: asynchronous assertion clears every stage to a bubble (sig_q, aluc_q, valid_q = 0) and counters to 0.
- While rst_n is low, `stall_dec` follows the `stall` inputs only.
- Release is synchronous to the first clka edge with rst_n high. Reset mid-stall discards held contents.
- Simultaneous flush[k] and stall[k]: bubble loaded at the edge.
- Simultaneous mispredict and stall[MISP_IDX+1]: stages 0..MISP_IDX are still killed, and stage MISP_IDX+1 holds.

## Configuration
- `CTRL_PIPE_PERF_EN` defined: two 16-bit saturating counters are instantiated.
  - `flush_cnt` increments once per edge where any valid stage is killed.
  - `bubble_cnt` increments once per edge where a bubble enters stage 0 or is inserted by the hold rule.
  - Both saturate at 16'hFFFF.
- Undefined: counters and their ports are absent; no other behaviour changes.

## Test plan
- Streaming: reset, then drive sig_d = 8'h01, 8'h21, 8'h90 with valid_d = 1 on consecutive edges, no stall/flush. Required: stage 2 shows 01, 21, 90 on edges 3, 4, 5; valid_q = 3'b111 from edge 3.
- Stall propagation: stall[1] = 1 for 2 cycles with the pipe full. Required:
  - stages 0 and 1 hold;
  - stage 2 receives 2 bubbles (sig 0, valid 0);
  - stall_dec = 1 for both cycles;
  - no instruction is duplicated or lost after release.
- Mispredict: branch (sig 8'h08) in stage 1 with pred_take = 0, actual_take = 1. Required: next edge stages 0 and 1 are bubbles and stage 2 = 8'h08; with valid_q[1] = 0 the same inputs give mispredict = 0 and no squash.
- Flush vs stall: flush[0] and stall[0] both high. Required: stage 0 becomes a bubble and stays one while the stall persists.
- Async reset: drop rst_n mid-cycle with the pipe full. Required: all outputs 0 immediately, before the next clka edge.
- PERF (macro defined): 3 mispredicts on valid entries plus 2 stall-induced bubbles. Required: flush_cnt = 3, bubble_cnt = 2; a counter preloaded near FFFF saturates at FFFF.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Parametrised control-signal pipeline (decode -> E/M/W...) with per-stage valid, stall, flush
// and mispredict squash. Define CTRL_PIPE_PERF_EN to add flush/bubble saturating counters.
module ctrl_pipe #(
    parameter int SIG_W    = 8,
    parameter int ALUC_W   = 3,
    parameter int STAGES   = 3,
    parameter int MISP_IDX = 1
) (
    input  logic                       clka,
    input  logic                       rst_n,
    input  logic [SIG_W-1:0]           sig_d,
    input  logic [ALUC_W-1:0]          aluc_d,
    input  logic                       valid_d,
    input  logic [STAGES-1:0]          stall,
    input  logic [STAGES-1:0]          flush,
    input  logic                       pred_take,
    input  logic                       actual_take,
    output logic [STAGES*SIG_W-1:0]    sig_q,
    output logic [STAGES*ALUC_W-1:0]   aluc_q,
    output logic [STAGES-1:0]          valid_q,
    output logic                       stall_dec,
    output logic                       mispredict
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [15:0]                flush_cnt,
    output logic [15:0]                bubble_cnt
`endif
);

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] kill;

    // Only a valid branch in the resolve stage may squash younger work.
    assign mispredict = valid_q[MISP_IDX] & (pred_take ^ actual_take);
    assign stall_dec  = hold[0];

`ifdef CTRL_PIPE_PERF_EN
    logic [STAGES-1:0] ins_bubble;
`endif

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [SIG_W-1:0]  up_sig;
        logic [ALUC_W-1:0] up_aluc;
        logic              up_valid;
        logic              up_hold;
        logic [SIG_W-1:0]  sig_reg;
        logic [ALUC_W-1:0] aluc_reg;
        logic              valid_reg;

        // A stall anywhere downstream freezes this stage too.
        assign hold[gi] = |stall[STAGES-1:gi];

        if (gi <= MISP_IDX) begin : g_misp
            assign kill[gi] = flush[gi] | mispredict;
        end else begin : g_nomisp
            assign kill[gi] = flush[gi];
        end

        if (gi == 0) begin : g_src_dec
            assign up_sig   = sig_d;
            assign up_aluc  = aluc_d;
            assign up_valid = valid_d;
            assign up_hold  = 1'b0;
        end else begin : g_src_stage
            assign up_sig   = sig_q[(gi-1)*SIG_W +: SIG_W];
            assign up_aluc  = aluc_q[(gi-1)*ALUC_W +: ALUC_W];
            assign up_valid = valid_q[gi-1];
            assign up_hold  = hold[gi-1];
        end

        always_ff @(posedge clka or negedge rst_n) begin
            if (!rst_n) begin
                sig_reg   <= '0;
                aluc_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (kill[gi]) begin
                sig_reg   <= '0;
                aluc_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (hold[gi]) begin
                sig_reg   <= sig_reg;
                aluc_reg  <= aluc_reg;
                valid_reg <= valid_reg;
            end else if (up_hold) begin
                // Upstream is frozen; forwarding it would duplicate the instruction.
                sig_reg   <= '0;
                aluc_reg  <= '0;
                valid_reg <= 1'b0;
            end else begin
                sig_reg   <= up_sig;
                aluc_reg  <= up_aluc;
                valid_reg <= up_valid;
            end
        end

        assign sig_q[gi*SIG_W +: SIG_W]    = sig_reg;
        assign aluc_q[gi*ALUC_W +: ALUC_W] = aluc_reg;
        assign valid_q[gi]                 = valid_reg;

`ifdef CTRL_PIPE_PERF_EN
        if (gi == 0) begin : g_bub_dec
            assign ins_bubble[gi] = ~kill[gi] & ~hold[gi] & ~valid_d;
        end else begin : g_bub_stage
            assign ins_bubble[gi] = ~kill[gi] & ~hold[gi] & hold[gi-1];
        end
`endif
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [15:0] flush_cnt_reg;
    logic [15:0] bubble_cnt_reg;
    logic        flush_evt;
    logic        bubble_evt;

    assign flush_evt  = |(kill & valid_q);
    assign bubble_evt = |ins_bubble;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (flush_evt && flush_cnt_reg != 16'hFFFF)
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
            if (bubble_evt && bubble_cnt_reg != 16'hFFFF)
                bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end

    assign flush_cnt  = flush_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule
